// File: rtl/micromind_pkg.sv
// Shared definitions for the micromind neuron pipeline: data format and
// the sequencer FSM encoding.
package micromind_pkg;

  localparam int DATA_W    = 8;
  localparam int FRAC_BITS = DATA_W - 1;

  typedef enum logic {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

  typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/neuron_weight_rf.sv
// Weight register file for one neuron: one synchronous write port, one
// combinational read port, asynchronous clear.
module neuron_weight_rf #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [N-1:0][DATA_W-1:0] mem;

  // Addresses at or beyond N match no entry, so they are silently dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (we && (wr_addr == IDX_W'(i))) mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N; i++)
      if (rd_addr == IDX_W'(i)) rd_data = mem[i];
  end

endmodule

// File: rtl/neuron_input_sequencer.sv
// Buffers one frame of N_INPUTS samples, then streams (sample, weight)
// pairs with index and last flag into the neuron MAC port.
module neuron_input_sequencer #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = micromind_pkg::DATA_W,
  parameter int IDX_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              w_we,
  input  logic [IDX_W-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_w,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [7:0]        frame_cnt
);
  import micromind_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  seq_state_t                   state, state_nx;
  logic                         live;
  logic [IDX_W-1:0]             load_idx;
  logic [N_INPUTS-1:0][DATA_W-1:0] sbuf;
  logic [IDX_W-1:0]             next_idx;
  logic [IDX_W-1:0]             rd_addr;
  logic [DATA_W-1:0]            rd_w;
  logic                         load_hs, load_done, issue_hs, last_acc;

  // live holds in_ready low until the first edge after reset release.
  assign in_ready  = live & (state == LOAD);
  assign load_hs   = in_valid & in_ready;
  assign load_done = load_hs & (load_idx == LAST_IDX);
  assign issue_hs  = out_valid & out_ready;
  assign out_last  = out_valid & (out_idx == LAST_IDX);
  assign last_acc  = issue_hs & out_last;
  assign next_idx  = out_idx + IDX_W'(1);
  assign rd_addr   = (state == ISSUE) ? next_idx : '0;

  neuron_weight_rf #(
    .N      (N_INPUTS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_wrf (
    .clk     (clk),
    .reset   (reset),
    .we      (w_we),
    .wr_addr (w_addr),
    .wr_data (w_data),
    .rd_addr (rd_addr),
    .rd_data (rd_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (load_done) state_nx = ISSUE;
      ISSUE:   if (last_acc)  state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live     <= 1'b0;
      load_idx <= '0;
      sbuf     <= '0;
    end else begin
      live <= 1'b1;
      if (load_hs) begin
        sbuf[load_idx] <= in_data;
        load_idx       <= load_done ? '0 : load_idx + IDX_W'(1);
      end
    end
  end

  // Pair registers capture the RF read before this edge's write lands,
  // which gives read-before-write on the presented weight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_w     <= '0;
      out_idx   <= '0;
      frame_cnt <= '0;
    end else if (load_done) begin
      out_valid <= 1'b1;
      out_idx   <= '0;
      out_x     <= sbuf[0];
      out_w     <= rd_w;
    end else if (issue_hs) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_idx   <= '0;
        out_x     <= '0;
        out_w     <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        out_idx <= next_idx;
        out_x   <= sbuf[next_idx];
        out_w   <= rd_w;
      end
    end
  end

endmodule

// File: doc/neuron_input_sequencer.md
Name: neuron_input_sequencer

Overview:
- Upstream feeder for the neuron stage.
- Collects one frame of N_INPUTS signed Q1.7 input samples from a valid/ready stream into a local buffer.
- Then issues them one per handshake as (input, weight) pairs, with index and last-flag, to the neuron's multiply-accumulate port.
- Holds a host-writable weight register file for the neuron.

Parameters:
- N_INPUTS, 8, inputs per neuron frame (≥2).
- DATA_W, 8, sample and weight width, signed Q1.(DATA_W-1).
- IDX_W, 3, index width; must equal clog2(N_INPUTS).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  upstream sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  DATA_W  signed sample
- w_we  in  1  weight write enable
- w_addr  in  IDX_W  weight index
- w_data  in  DATA_W  signed weight
- out_valid  out  1  pair valid toward neuron
- out_ready  in  1  neuron accepts pair
- out_x  out  DATA_W  input sample
- out_w  out  DATA_W  matching weight
- out_idx  out  IDX_W  index of presented pair
- out_last  out  1  presented pair is index N_INPUTS-1
- frame_cnt  out  8  completed frames issued, wraps 255→0

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; in_ready=0 while reset is asserted.
  - FSM to LOAD; load/issue counters 0; weights cleared to 0; sample buffer cleared.
  - Deassertion is sampled synchronously; in_ready=1 on the first clk edge after release.
- FSM states:
  - LOAD:
    - in_ready=1.
    - On in_valid&in_ready, store in_data at buf[load_idx] and increment load_idx.
    - On the store with load_idx==N_INPUTS-1, go to ISSUE and clear load_idx.
  - ISSUE:
    - in_ready=0.
    - On the first ISSUE cycle, register pair 0: out_x=buf[0], out_w=weight[0], out_idx=0, out_valid=1.
    - On out_valid&out_ready, advance to the next index next cycle; out_valid stays high with no bubbles.
    - When the pair with out_last=1 is accepted: out_valid=0 next cycle, frame_cnt+1, return to LOAD.
  - Latency from the final sample accepted to out_valid=1 is exactly 1 cycle.
  - Frame turnaround from the last pair accepted to in_ready=1 is 1 cycle.
- Output stability: while out_valid=1 and out_ready=0, out_x/out_w/out_idx/out_last hold constant.
- out_last = out_valid & (out_idx==N_INPUTS-1).
- Weight writes:
  - Accepted in any state.
  - weight[w_addr] updates at the clock edge.
  - A write in the same cycle the pair for that address is registered is not seen: the old value is presented (read-before-write).
  - A write to an index not yet issued in the current frame is seen.
- Width rules:
  - No arithmetic on data; values are passed bit-exact and sign preserved.
  - w_addr ≥ N_INPUTS (non-power-of-2 N) is ignored.
- No input back-pressure loss: samples presented while in_ready=0 are not consumed.
- Reset mid-frame discards partial load or issue.
  - frame_cnt is not incremented for the aborted frame.

Decomposition:
- Shared package micromind_pkg:
  - DATA_W default.
  - Q-format fractional-bits constant (FRAC_BITS=DATA_W-1).
  - FSM state encoding (LOAD=0, ISSUE=1).
  - Common signed sample typedef, also used by the neuron stage.
- One sub-module is natural: neuron_weight_rf.
  - N_INPUTS×DATA_W register file.
  - One synchronous write port, one combinational read port, async active-low clear.

Test Plan:
- Basic frame: weights w[i]=i+1; stream samples 0x10..0x17 with out_ready=1.
  - Expect in_ready drop 1 cycle after the 8th sample.
  - Expect pairs (0x10,1)…(0x17,8) on consecutive cycles, out_last only with idx 7, frame_cnt=1.
- Back-pressure: toggle out_ready 1-0-0-1 pattern.
  - Expect outputs held constant during stalls.
  - Expect each index issued exactly once, in order.
- Upstream gaps: in_valid random 50%.
  - Expect the buffer captures only handshaken samples.
  - Signed values 0x80, 0x7F, 0xFF must reappear bit-exact on out_x.
- Weight write during ISSUE: while idx 2 is presented, write w[5]=0xC0 and w[1]=0x33.
  - Expect idx5 issued with out_w=0xC0; frame 1 keeps old w[1].
  - Expect w[1]=0x33 in the next frame.
- Reset mid-issue: drive reset=0 asynchronously at idx 4.
  - Expect out_valid=0, in_ready=0, frame_cnt unchanged and all weights read as 0 immediately.
  - After release, a fresh 8-sample frame issues from idx 0.
- Wrap: run 256 frames → frame_cnt returns to 0; no missed or duplicated pairs.
